fir_coeff_bank: RTL
===================

// Module: fir_coeff_bank
// PURPOSE
//  Double-buffered coefficient store serving the pulse-shaping FIR's per-tap coefficient fetch.
//  Host side streams a full tap set into the shadow bank over a valid/ready write port.
//  Filter side reads the active bank by address with 1-cycle latency.
//  A complete, correctly framed load swaps banks atomically between read bursts, so taps never mix sets.
// PARAMETERS
//  N_TAPS     71     number of coefficients per set
//  COEF_W     8      coefficient width, unsigned
//  ADDR_W     7      address/pointer width; must satisfy 2**ADDR_W >= N_TAPS
//  RESET_COEF 8'h01  value of every entry in both banks after reset
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst_n        in   1       reset, asynchronous, active-low
//  wr_valid     in   1       host beat valid
//  wr_ready     out  1       block accepts a beat this cycle
//  wr_data      in   COEF_W  coefficient for tap = current write pointer
//  wr_last      in   1       marks final beat of a set
//  rd_en        in   1       filter read request
//  rd_addr      in   ADDR_W  tap index to read
//  rd_data      out  COEF_W  registered read data
//  rd_valid     out  1       rd_data valid; follows rd_en by 1 cycle
//  bank_ready   out  1       active bank holds a committed set
//  swap_pulse   out  1       1-cycle pulse on the cycle banks swap
//  load_err     out  1       1-cycle pulse when a load is rejected
//  wr_count     out  ADDR_W  beats accepted into current load
// BEHAVIOUR
//  Reset: both banks = RESET_COEF; active=bank0; state IDLE; wr_ptr=0; rd_data=0; rd_valid=0;
//   bank_ready=1; swap_pulse=0; load_err=0; wr_count=0; wr_ready=1.
//  Beat accepted iff wr_valid & wr_ready. Accepted beat writes shadow[wr_ptr]; wr_ptr, wr_count += 1.
//  FSM IDLE/LOAD/PENDING/ERR. wr_ready=1 in IDLE and LOAD, 0 in PENDING and ERR.
//   IDLE:    accepted beat -> LOAD (with wr_last and N_TAPS>1 -> ERR).
//   LOAD:    accepted beat at wr_ptr==N_TAPS-1: wr_last=1 -> PENDING; wr_last=0 -> ERR (overlong).
//            accepted beat with wr_last=1 at wr_ptr<N_TAPS-1 -> ERR (short). Data already written stays
//            in shadow but is never activated.
//   PENDING: first cycle with rd_en=0 -> toggle active bank, swap_pulse=1, wr_ptr=0, wr_count=0 -> IDLE.
//            Swap is deferred as long as rd_en stays high; no write is accepted meanwhile.
//   ERR:     load_err=1 for exactly that cycle; wr_ptr=0; wr_count=0; -> IDLE next cycle.
//  bank_ready stays 1 after reset (reset set is a valid set); never deasserts.
//  Read: rd_en=1 in cycle t -> cycle t+1: rd_valid=1, rd_data=active[rd_addr] sampled at t.
//   rd_addr >= N_TAPS -> rd_data=0, rd_valid=1. rd_en=0 -> rd_valid=0, rd_data holds last value.
//   Reads never return shadow contents; a swap never coincides with a read cycle.
//  Simultaneous write beat and read: independent (different banks), both proceed.
//  Reset mid-load or in PENDING: load discarded, all state returns to reset values (both banks reloaded).
//  Throughput: one write beat per cycle; one read per cycle.
// TESTING
//  T1 reset -> rd_addr=0..70 each read 8'h01, rd_valid 1 cycle after rd_en; bank_ready=1, wr_ready=1.
//  T2 stream 71 beats data=k+1 (k=0..70), wr_last on 71st, rd_en=0 -> swap_pulse 1 cycle after
//     PENDING; then read addr 5 -> 8'h06, addr 70 -> 8'h47.
//  T3 stream 10 beats, wr_last on 10th -> load_err pulse, no swap_pulse, addr 3 still reads prior set.
//  T4 stream 71 beats without wr_last -> load_err on cycle after 71st beat; active bank unchanged.
//  T5 complete load while rd_en held high 20 cycles -> no swap, wr_ready=0 throughout; rd_en drops
//     -> swap_pulse that cycle+1; reads issued before swap return old set.
//  T6 assert rst_n=0 after 30 beats of a load -> wr_count=0, all reads 8'h01; rd_addr=100 -> rd_data=0.

Source files
------------

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient store for the pulse-shaping FIR.
// The host streams a full tap set into the shadow bank. The filter reads the
// active bank with 1-cycle latency. A correctly framed load swaps banks
// atomically, and only on a cycle with no read in flight.
module fir_coeff_bank #(
    parameter int unsigned          N_TAPS     = 71,
    parameter int unsigned          COEF_W     = 8,
    parameter int unsigned          ADDR_W     = 7,
    parameter logic [COEF_W-1:0]    RESET_COEF = 8'h01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [COEF_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              bank_ready,
    output logic              swap_pulse,
    output logic              load_err,
    output logic [ADDR_W-1:0] wr_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PENDING,
        S_ERR
    } state_t;

    state_t              state_q;
    logic                active_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   wr_count_q;
    logic                swap_pulse_q;
    logic                load_err_q;
    logic                bank_ready_q;
    logic [COEF_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic [COEF_W-1:0]   mem_q [2][N_TAPS];

    logic                wr_accept;
    logic                shadow_sel;

    // Beats are taken only while collecting a set; PENDING and ERR stall the host.
    always_comb begin
        wr_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
        wr_accept  = wr_valid && wr_ready;
        shadow_sel = ~active_q;
    end

    // Load-framing FSM: tracks the write pointer, validates framing, and commits the swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            active_q     <= 1'b0;
            wr_ptr_q     <= '0;
            wr_count_q   <= '0;
            swap_pulse_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            swap_pulse_q <= 1'b0;
            load_err_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (wr_accept) begin
                        if (wr_ptr_q == LAST_IDX) begin
                            if (wr_last) begin
                                state_q    <= S_PENDING;
                                wr_ptr_q   <= wr_ptr_q + 1'b1;
                                wr_count_q <= wr_count_q + 1'b1;
                            end else begin
                                // Overlong set: the pointer is cleared on entry so ERR already shows 0.
                                state_q    <= S_ERR;
                                load_err_q <= 1'b1;
                                wr_ptr_q   <= '0;
                                wr_count_q <= '0;
                            end
                        end else if (wr_last) begin
                            state_q    <= S_ERR;
                            load_err_q <= 1'b1;
                            wr_ptr_q   <= '0;
                            wr_count_q <= '0;
                        end else begin
                            state_q    <= S_LOAD;
                            wr_ptr_q   <= wr_ptr_q + 1'b1;
                            wr_count_q <= wr_count_q + 1'b1;
                        end
                    end
                end
                S_PENDING: begin
                    // Swap only on a cycle with no read, so no read ever straddles two sets.
                    if (!rd_en) begin
                        state_q      <= S_IDLE;
                        active_q     <= ~active_q;
                        swap_pulse_q <= 1'b1;
                        wr_ptr_q     <= '0;
                        wr_count_q   <= '0;
                    end
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Coefficient storage: both banks reload on reset; accepted beats land in the shadow bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned t = 0; t < N_TAPS; t++) begin
                    mem_q[b][t] <= RESET_COEF;
                end
            end
        end else if (wr_accept) begin
            mem_q[shadow_sel][wr_ptr_q] <= wr_data;
        end
    end

    // Registered read of the active bank; out-of-range taps return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                if (rd_addr <= LAST_IDX) begin
                    rd_data_q <= mem_q[active_q][rd_addr];
                end else begin
                    rd_data_q <= '0;
                end
            end
        end
    end

    // The reset set is itself a committed set, so the active bank is always usable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_ready_q <= 1'b1;
        end else begin
            bank_ready_q <= 1'b1;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign bank_ready = bank_ready_q;
    assign swap_pulse = swap_pulse_q;
    assign load_err   = load_err_q;
    assign wr_count   = wr_count_q;

endmodule
